sextium_avalon_fifo_io: RTL and testbench



---
 rtl/sextium_avalon_fifo_io_pkg.sv | 27 ++
 rtl/sextium_avalon_fifo_io_if.sv | 23 ++
 rtl/sextium_avalon_fifo_io_sync_fifo.sv | 59 +++++
 rtl/sextium_avalon_fifo_io.sv | 125 ++++++++++++
 tb/tb_sextium_avalon_fifo_io.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sextium_avalon_fifo_io_pkg.sv
// Shared address map, widths and types for the Sextium I/O FIFO responder.
// The CPU-side I/O bridge imports the same address constants.
package sextium_avalon_fifo_io_pkg;

   localparam int unsigned BUS_W  = 32;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned BE_W   = 4;

   localparam logic [BUS_W-1:0] IO_ADDR_OFFSET       = 32'h0002_0000;
   localparam logic [BUS_W-1:0] READ_FIFO_ADDR_DFLT  = 32'h0002_1000;
   localparam logic [BUS_W-1:0] WRITE_FIFO_ADDR_DFLT = 32'h0002_2000;
   localparam logic [BUS_W-1:0] STATUS_ADDR_DFLT     = 32'h0002_3000;

   typedef enum logic [1:0] {
      ACC_NONE,
      ACC_POP,
      ACC_PUSH,
      ACC_STATUS
   } access_e;

   typedef struct packed {
      logic [15:0] rsvd;
      logic [7:0]  out_free;
      logic [7:0]  in_count;
   } status_word_t;

endpackage

// File: rtl/sextium_avalon_fifo_io_if.sv
// Avalon-MM bus between the Sextium I/O bridge (master) and the FIFO responder.
interface sextium_avalon_fifo_io_if;
   import sextium_avalon_fifo_io_pkg::*;

   logic [BUS_W-1:0] address;
   logic             read;
   logic             write;
   logic [BUS_W-1:0] writedata;
   logic [BE_W-1:0]  byteenable;
   logic [BUS_W-1:0] readdata;
   logic             waitrequest;

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, waitrequest
   );

endinterface

// File: rtl/sextium_avalon_fifo_io_sync_fifo.sv
// sextium_sync_fifo: show-ahead synchronous FIFO with registered full/empty
// flags and an occupancy count; push/pop requests past the flags are ignored.
module sextium_sync_fifo #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;
   logic [CNT_W-1:0]      count_nxt;

   always_comb begin
      do_push   = push & ~full;
      do_pop    = pop & ~empty;
      count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   assign head = mem[rd_ptr];

   // Storage needs no reset; the flags guard every read of it.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/sextium_avalon_fifo_io.sv
// Avalon-MM responder holding the CPU input and output FIFOs for the Sextium
// I/O bridge. Define SEXTIUM_FIFO_IO_STATUS_EN to map the status word.
module sextium_avalon_fifo_io
   import sextium_avalon_fifo_io_pkg::*;
#(
   parameter logic [BUS_W-1:0] READ_FIFO_ADDR  = READ_FIFO_ADDR_DFLT,
   parameter logic [BUS_W-1:0] WRITE_FIFO_ADDR = WRITE_FIFO_ADDR_DFLT,
   parameter int unsigned      DEPTH_LOG2      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   sextium_avalon_fifo_io_if.slave avs,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

   logic              in_full;
   logic              in_empty;
   logic              out_full;
   logic              out_empty;
   logic [DATA_W-1:0] in_head;
   logic [CNT_W-1:0]  in_count;
   logic [CNT_W-1:0]  out_count;
   logic              host_push;
   logic              host_pop;
   logic              cpu_pop;
   logic              cpu_push;
   access_e           access;
   status_word_t      status_word;
   logic              unused_bus;

   // Address decode; read wins when read and write are both asserted.
   always_comb begin
      access = ACC_NONE;
      if (avs.read) begin
         if (avs.address == READ_FIFO_ADDR) begin
            access = ACC_POP;
         end
`ifdef SEXTIUM_FIFO_IO_STATUS_EN
         else if (avs.address == STATUS_ADDR_DFLT) begin
            access = ACC_STATUS;
         end
`endif
      end else if (avs.write && (avs.address == WRITE_FIFO_ADDR)) begin
         access = ACC_PUSH;
      end
   end

   always_comb begin
      status_word          = '0;
      status_word.out_free = 8'(CNT_W'(DEPTH) - out_count);
      status_word.in_count = 8'(in_count);
   end

   // Stall only on empty-input reads and full-output writes; flags are
   // registered, so same-cycle host traffic never bypasses a stall.
   always_comb begin
      avs.waitrequest = 1'b0;
      avs.readdata    = '0;
      cpu_pop         = 1'b0;
      cpu_push        = 1'b0;
      case (access)
         ACC_POP: begin
            avs.waitrequest = in_empty;
            if (!in_empty) begin
               avs.readdata = {16'h0, in_head};
               cpu_pop      = 1'b1;
            end
         end
         ACC_PUSH: begin
            avs.waitrequest = out_full;
            cpu_push        = ~out_full;
         end
         ACC_STATUS: avs.readdata = status_word;
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = ~in_full & ~reset;
      host_push = in_valid & in_ready;
      out_valid = ~out_empty;
      host_pop  = out_valid & out_ready;
   end

   assign unused_bus = ^{avs.byteenable, avs.writedata[BUS_W-1:DATA_W]};

   sextium_sync_fifo #(
      .WIDTH      (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_in_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (host_push),
      .push_data (in_data),
      .pop       (cpu_pop),
      .head      (in_head),
      .full      (in_full),
      .empty     (in_empty),
      .count     (in_count)
   );

   sextium_sync_fifo #(
      .WIDTH      (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_out_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cpu_push),
      .push_data (avs.writedata[DATA_W-1:0]),
      .pop       (host_pop),
      .head      (out_data),
      .full      (out_full),
      .empty     (out_empty),
      .count     (out_count)
   );

endmodule

// File: tb/tb_sextium_avalon_fifo_io.sv
// Directed bench for sextium_avalon_fifo_io: vector table plus multi-cycle
// sequences for stalls, wrap, simultaneous push/pop and reset mid-stall.
module tb_sextium_avalon_fifo_io;

   logic        clk;
   logic        reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int checks;
   int failures;

   localparam logic [31:0] A_RD  = 32'h0002_1000;
   localparam logic [31:0] A_WR  = 32'h0002_2000;
   localparam logic [31:0] A_ST  = 32'h0002_3000;
   localparam logic [31:0] A_UNM = 32'h0002_4000;

   sextium_avalon_fifo_io_if bus ();

   sextium_avalon_fifo_io dut (
      .clk       (clk),
      .reset     (reset),
      .avs       (bus),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        iv;
      logic [15:0] idata;
      logic        ordy;
      logic        exp_wait;
      logic [31:0] exp_rdata;
      logic        exp_in_ready;
      logic        exp_out_valid;
      logic [15:0] exp_out_data;
   } vec_t;

   function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                               logic iv, logic [15:0] idata, logic ordy, logic ew,
                               logic [31:0] erd, logic eir, logic eov, logic [15:0] eod);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.iv = iv; v.idata = idata; v.ordy = ordy;
      v.exp_wait = ew; v.exp_rdata = erd; v.exp_in_ready = eir;
      v.exp_out_valid = eov; v.exp_out_data = eod;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata);
      bus.read      = rd;
      bus.write     = wr;
      bus.address   = addr;
      bus.writedata = wdata;
   endtask

   vec_t vecs[12];
   logic [31:0] status_exp;
   logic [31:0] status_d_exp;

   initial begin
      checks = 0;
      failures = 0;
`ifdef SEXTIUM_FIFO_IO_STATUS_EN
      status_exp   = 32'h0000_0F00;
      status_d_exp = 32'h0000_0E05;
`else
      status_exp   = 32'h0;
      status_d_exp = 32'h0;
`endif
      //            rd  wr  addr   wdata          iv  idata     ordy ew  erd             eir eov eod
      vecs[0]  = mk(0, 0, A_RD,  32'h0,         0, 16'h0,    0,  0, 32'h0,          1, 0, 16'h0);
      vecs[1]  = mk(1, 0, A_RD,  32'h0,         1, 16'hBEEF, 0,  1, 32'h0,          1, 0, 16'h0);
      vecs[2]  = mk(1, 0, A_RD,  32'h0,         0, 16'h0,    0,  0, 32'h0000_BEEF,  1, 0, 16'h0);
      vecs[3]  = mk(1, 0, A_RD,  32'h0,         0, 16'h0,    0,  1, 32'h0,          1, 0, 16'h0);
      vecs[4]  = mk(0, 1, A_WR,  32'hABCD_1234, 0, 16'h0,    0,  0, 32'h0,          1, 0, 16'h0);
      vecs[5]  = mk(0, 0, A_RD,  32'h0,         0, 16'h0,    0,  0, 32'h0,          1, 1, 16'h1234);
      vecs[6]  = mk(1, 0, A_UNM, 32'h0,         0, 16'h0,    0,  0, 32'h0,          1, 1, 16'h1234);
      vecs[7]  = mk(0, 1, A_RD,  32'h5,         0, 16'h0,    0,  0, 32'h0,          1, 1, 16'h1234);
      vecs[8]  = mk(1, 0, A_ST,  32'h0,         0, 16'h0,    0,  0, status_exp,     1, 1, 16'h1234);
      vecs[9]  = mk(1, 1, A_WR,  32'h9999,      0, 16'h0,    0,  0, 32'h0,          1, 1, 16'h1234);
      vecs[10] = mk(0, 0, A_RD,  32'h0,         0, 16'h0,    1,  0, 32'h0,          1, 1, 16'h1234);
      vecs[11] = mk(1, 0, A_RD,  32'h0,         0, 16'h0,    0,  1, 32'h0,          1, 0, 16'h0);

      reset = 1'b1;
      cpu(0, 0, 32'h0, 32'h0);
      bus.byteenable = 4'hF;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_in_ready",  32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_wait",      32'(bus.waitrequest), 32'h0);
      chk("rst_rdata",     bus.readdata, 32'h0);
      reset = 1'b0;
      tick();

      // Vector table: one cycle per row, outputs checked before the edge.
      for (int i = 0; i < 12; i++) begin
         cpu(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         in_valid = vecs[i].iv; in_data = vecs[i].idata; out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("v%0d_wait", i), 32'(bus.waitrequest), 32'(vecs[i].exp_wait));
         chk($sformatf("v%0d_rdata", i), bus.readdata, vecs[i].exp_rdata);
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_out_valid));
         if (vecs[i].exp_out_valid)
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_out_data));
         tick();
      end
      cpu(0, 0, 32'h0, 32'h0); in_valid = 0; out_ready = 0;

      // Output FIFO fill, stall on 17th write, no bypass on host pop, drain.
      for (int i = 1; i <= 16; i++) begin
         cpu(0, 1, A_WR, 32'(i));
         #1 chk($sformatf("fill%0d_wait", i), 32'(bus.waitrequest), 32'h0);
         tick();
      end
      cpu(0, 1, A_WR, 32'd17);
      #1 chk("w17_stall", 32'(bus.waitrequest), 32'h1);
      chk("w17_head", 32'(out_data), 32'd1);
      out_ready = 1;
      #1 chk("w17_no_bypass", 32'(bus.waitrequest), 32'h1);
      tick();
      out_ready = 0;
      #1 chk("w17_done", 32'(bus.waitrequest), 32'h0);
      tick();
      cpu(0, 0, 32'h0, 32'h0);
      out_ready = 1;
      for (int i = 2; i <= 17; i++) begin
         #1 chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'h1);
         chk($sformatf("drain%0d_data", i), 32'(out_data), 32'(i));
         tick();
      end
      out_ready = 0;
      #1 chk("drain_empty", 32'(out_valid), 32'h0);

      // Host streams 20 words; in_ready drops after 16; pointers wrap.
      for (int i = 0; i < 20; i++) begin
         in_valid = 1; in_data = 16'(256 + i);
         #1 chk($sformatf("stream%0d_ready", i), 32'(in_ready), (i < 16) ? 32'h1 : 32'h0);
         tick();
      end
      in_data = 16'h7777;
      cpu(1, 0, A_RD, 32'h0);
      #1 chk("full_pop_no_ready", 32'(in_ready), 32'h0);
      chk("full_pop_wait", 32'(bus.waitrequest), 32'h0);
      chk("full_pop_data", bus.readdata, 32'd256);
      tick();
      in_valid = 0;
      for (int i = 1; i < 16; i++) begin
         #1 chk($sformatf("rd%0d_wait", i), 32'(bus.waitrequest), 32'h0);
         chk($sformatf("rd%0d_data", i), bus.readdata, 32'(256 + i));
         tick();
      end
      #1 chk("rd_empty_stall", 32'(bus.waitrequest), 32'h1);
      cpu(0, 0, 32'h0, 32'h0);

      // Three words held; simultaneous host push and CPU pop.
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1; in_data = 16'(i);
         tick();
      end
      in_data = 16'd4;
      cpu(1, 0, A_RD, 32'h0);
      #1 chk("sim_wait", 32'(bus.waitrequest), 32'h0);
      chk("sim_data", bus.readdata, 32'd1);
      chk("sim_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 0;
      for (int i = 2; i <= 4; i++) begin
         #1 chk($sformatf("sim_rd%0d", i), bus.readdata, 32'(i));
         tick();
      end
      #1 chk("sim_count3_empty", 32'(bus.waitrequest), 32'h1);
      cpu(0, 0, 32'h0, 32'h0);

      // Status word with 5 input and 2 output words (zero when unmapped).
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; in_data = 16'(16'hA0 + i);
         if (i < 2) cpu(0, 1, A_WR, 32'(16'hC0 + i));
         else       cpu(0, 0, 32'h0, 32'h0);
         tick();
      end
      in_valid = 0;
      cpu(1, 0, A_ST, 32'h0);
      #1 chk("status_rdata", bus.readdata, status_d_exp);
      chk("status_wait", 32'(bus.waitrequest), 32'h0);
      tick();
      cpu(0, 0, 32'h0, 32'h0);

      // Reset while a read stalls on an empty FIFO with host data in flight.
      reset = 1; tick(); reset = 0; tick();
      cpu(1, 0, A_RD, 32'h0);
      in_valid = 1; in_data = 16'h5555; reset = 1;
      #1 chk("rst_stall_in_ready", 32'(in_ready), 32'h0);
      chk("rst_stall_wait", 32'(bus.waitrequest), 32'h1);
      tick();
      reset = 0; in_valid = 0;
      #1 chk("post_rst_rd_wait", 32'(bus.waitrequest), 32'h1);
      chk("post_rst_out_valid", 32'(out_valid), 32'h0);
      cpu(0, 0, 32'h0, 32'h0);
      tick();

      // Reset while a write stalls on a full output FIFO.
      for (int i = 0; i < 16; i++) begin
         cpu(0, 1, A_WR, 32'(i));
         tick();
      end
      cpu(0, 1, A_WR, 32'h99);
      #1 chk("wstall_wait", 32'(bus.waitrequest), 32'h1);
      reset = 1;
      tick();
      reset = 0;
      #1 chk("post_rst_wr_wait", 32'(bus.waitrequest), 32'h0);
      chk("post_rst_wr_out_valid", 32'(out_valid), 32'h0);
      cpu(0, 0, 32'h0, 32'h0);
      tick();
      #1 chk("post_rst_no_push", 32'(out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
